audio_proc_gen: RTL and testbench
=================================

// Module: audio_proc_gen
// PURPOSE
// Parametrised per-frame audio processor between the AC'97 controller and codec output.
// Once per AC'97 frame it captures left/right PCM samples and produces new left/right
// output samples. The source is selected by mode: mute, loopback, square-wave tone, or
// tone mixed with input. Adds per-block attenuation, mono duplication, a tone-period
// update free of glitches, an output-valid strobe and a heartbeat LED.
// PARAMETERS
// SAMPLE_W  20        PCM sample width, signed two's complement
// DIV_W     16        width of tone half-period (in frames)
// TONE_AMP  20'h08000 tone magnitude; tone sample = +TONE_AMP or -TONE_AMP
// LED_DIV   14        LED toggles every 2**LED_DIV frames
// PORTS
// clock        in   1         system clock
// reset_n      in   1         asynchronous active-low reset
// ready        in   1         AC'97 frame-ready level; asynchronous to clock
// left_in      in   SAMPLE_W  PCM from AC'97, left
// right_in     in   SAMPLE_W  PCM from AC'97, right
// mode         in   2         00 mute, 01 loopback, 10 tone, 11 tone+input mix
// mono         in   1         1: right path uses left_in instead of right_in
// atten        in   3         arithmetic right shift applied to input samples (0..7)
// half_period  in   DIV_W     tone half-period in frames; 0 = tone silent (0)
// left_out     out  SAMPLE_W  PCM to AC'97, left (registered)
// right_out    out  SAMPLE_W  PCM to AC'97, right (registered)
// out_valid    out  1         one-cycle pulse when outputs update
// LED          out  1         heartbeat
// BEHAVIOUR
// - Reset (async, reset_n=0): left_out=right_out=0, out_valid=0, LED=0, tone phase=0,
//   frame counter=0, latched half-period=0, ready synchronisers=0.
// - ready passes through a 2-flop synchroniser, followed by a rising-edge detect. A
//   1-cycle frame strobe occurs per rising edge. ready high for many cycles gives one strobe.
// - Latency: the first clock edge that samples ready=1 is edge k. Outputs and out_valid
//   change at edge k+3. out_valid is high for exactly one cycle.
// - mode, mono, atten and half_period are sampled only on the strobe cycle. A change
//   between strobes takes effect at the next frame.
// - Input path: inL = left_in >>> atten; inR = (mono ? left_in : right_in) >>> atten
//   (sign-preserving).
// - Tone counter counts frames. At a strobe with hp_latched!=0: if cnt==hp_latched-1,
//   set cnt=0, toggle phase and latch new half_period into hp_latched. Otherwise cnt++.
// - If hp_latched==0, the new half_period is latched on every strobe and phase is held at 0.
// - tone = (hp_latched==0) ? 0 : (phase ? +TONE_AMP : -TONE_AMP). The tone sample uses the
//   phase value before this frame's toggle.
// - Outputs per mode: 00 -> 0/0; 01 -> inL/inR; 10 -> tone/tone.
// - Mode 11 -> sat(inL+tone)/sat(inR+tone). The sum is computed at SAMPLE_W+1 bits and
//   clamped to [-2**(SAMPLE_W-1), 2**(SAMPLE_W-1)-1].
// - Tone counter and phase advance in every mode, so the tone stays continuous across
//   mode switches.
// - LED toggles when a LED_DIV-bit frame counter wraps from all-ones to 0.
// - Reset mid-frame: all state clears immediately. The first strobe after release is
//   handled as frame 0.
// TESTING
// - Reset: hold reset_n=0 with ready toggling -> outputs 0, out_valid never high; release
//   gives first out_valid 3 edges after ready is sampled high.
// - Loopback: mode=01, atten=0, left_in=20'h12345, right_in=20'hFEDCB -> left_out=20'h12345,
//   right_out=20'hFEDCB. Add atten=2, left_in=20'h80000 -> left_out=20'hE0000.
// - Tone: mode=10, half_period=4 -> frames give -AMP x4, +AMP x4, repeating
//   (20'hF8000 / 20'h08000).
// - Period change: switch half_period 4->2 in the middle of a half-period -> the current
//   half-period completes at 4 frames, then half-periods of 2 frames follow.
// - Mix saturation: mode=11, left_in=20'h7F000, phase + -> left_out=20'h7FFFF; with
//   left_in=20'h80100 and phase - -> left_out=20'h80000.
// - Mono and strobe: mono=1, mode=01, ready held high for 50 cycles -> right_out==left_in,
//   exactly one out_valid. LED toggles after 2**LED_DIV frames.

Source files
------------

// File: rtl/audio_proc_gen.sv
// audio_proc_gen: per-frame audio processor sitting between the AC'97
// controller and the codec output path.
//
// Each AC'97 frame is announced by a rising edge on the asynchronous
// 'ready' level. The rising edge is synchronised and turned into a
// one-cycle frame strobe. On that strobe the block:
//   - captures the attenuated left/right inputs,
//   - captures the mode and the current tone sample,
//   - advances the tone generator and the heartbeat frame counter.
// One cycle later the new output pair is registered and out_valid pulses.
// From the first clock edge that samples ready=1, the outputs update
// three edges later.
//
// Ports
//   clock        system clock
//   reset_n      asynchronous active-low reset
//   ready        AC'97 frame-ready level (asynchronous to clock)
//   left_in      PCM sample from AC'97, left (signed)
//   right_in     PCM sample from AC'97, right (signed)
//   mode         00 mute, 01 loopback, 10 tone, 11 tone + input mix
//   mono         1: right path takes left_in
//   atten        arithmetic right shift applied to the input samples
//   half_period  tone half-period in frames, 0 silences the tone
//   left_out     registered PCM to AC'97, left
//   right_out    registered PCM to AC'97, right
//   out_valid    one-cycle pulse when left_out/right_out update
//   LED          heartbeat, toggles every 2**LED_DIV frames
module audio_proc_gen #(
  parameter int                  SAMPLE_W = 20,
  parameter int                  DIV_W    = 16,
  parameter logic [SAMPLE_W-1:0] TONE_AMP = 20'h08000,
  parameter int                  LED_DIV  = 14
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                ready,
  input  logic [SAMPLE_W-1:0] left_in,
  input  logic [SAMPLE_W-1:0] right_in,
  input  logic [1:0]          mode,
  input  logic                mono,
  input  logic [2:0]          atten,
  input  logic [DIV_W-1:0]    half_period,
  output logic [SAMPLE_W-1:0] left_out,
  output logic [SAMPLE_W-1:0] right_out,
  output logic                out_valid,
  output logic                LED
);

  localparam logic [SAMPLE_W-1:0] SAT_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] SAT_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

  // ready synchroniser; ready_s3 only serves the rising-edge detect
  logic ready_s1_reg, ready_s2_reg, ready_s3_reg;
  logic strobe;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready_s1_reg <= 1'b0;
      ready_s2_reg <= 1'b0;
      ready_s3_reg <= 1'b0;
    end else begin
      ready_s1_reg <= ready;
      ready_s2_reg <= ready_s1_reg;
      ready_s3_reg <= ready_s2_reg;
    end
  end

  assign strobe = ready_s2_reg & ~ready_s3_reg;

  // Tone generator. The half-period is only reloaded at a phase boundary
  // (or while silent) so a period change never produces a short half-cycle.
  logic [DIV_W-1:0]           hp_latched_reg, tone_cnt_reg;
  logic                       phase_reg;
  logic signed [SAMPLE_W-1:0] tone_now;

  assign tone_now = (hp_latched_reg == '0) ? '0 :
                    (phase_reg ? $signed(TONE_AMP) : -$signed(TONE_AMP));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hp_latched_reg <= '0;
      tone_cnt_reg   <= '0;
      phase_reg      <= 1'b0;
    end else if (strobe) begin
      if (hp_latched_reg == '0) begin
        hp_latched_reg <= half_period;
        phase_reg      <= 1'b0;
      end else if (tone_cnt_reg == hp_latched_reg - 1'b1) begin
        tone_cnt_reg   <= '0;
        phase_reg      <= ~phase_reg;
        hp_latched_reg <= half_period;
      end else begin
        tone_cnt_reg   <= tone_cnt_reg + 1'b1;
      end
    end
  end

  // Heartbeat: toggle when the frame counter wraps from all-ones to zero
  logic [LED_DIV-1:0] frame_cnt_reg;
  logic               led_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_reg <= '0;
      led_reg       <= 1'b0;
    end else if (strobe) begin
      frame_cnt_reg <= frame_cnt_reg + 1'b1;
      if (&frame_cnt_reg)
        led_reg <= ~led_reg;
    end
  end

  assign LED = led_reg;

  // Capture stage: everything the output stage needs is frozen on the strobe
  // (tone_now is the pre-toggle sample), so later input changes are ignored.
  logic [1:0]                 mode_reg;
  logic signed [SAMPLE_W-1:0] tone_reg;
  logic                       capture_valid_reg;
  logic                       out_valid_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_reg          <= 2'b00;
      tone_reg          <= '0;
      capture_valid_reg <= 1'b0;
      out_valid_reg     <= 1'b0;
    end else begin
      capture_valid_reg <= strobe;
      out_valid_reg     <= capture_valid_reg;
      if (strobe) begin
        mode_reg <= mode;
        tone_reg <= tone_now;
      end
    end
  end

  assign out_valid = out_valid_reg;

  // Per-channel datapath: channel 0 = left, channel 1 = right
  logic [SAMPLE_W-1:0] chan_src [2];
  logic [SAMPLE_W-1:0] chan_out [2];

  assign chan_src[0] = left_in;
  assign chan_src[1] = mono ? left_in : right_in;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic signed [SAMPLE_W-1:0] in_next, in_reg;
      logic [SAMPLE_W:0]          sum;
      logic [SAMPLE_W-1:0]        out_next, out_reg;

      assign in_next = $signed(chan_src[gi]) >>> atten;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
          in_reg <= '0;
        else if (strobe)
          in_reg <= in_next;
      end

      // One extra bit holds any input+tone sum; the top two bits differ on overflow
      assign sum = {in_reg[SAMPLE_W-1], in_reg} + {tone_reg[SAMPLE_W-1], tone_reg};

      always_comb begin
        out_next = '0;
        case (mode_reg)
          2'b00: out_next = '0;
          2'b01: out_next = in_reg;
          2'b10: out_next = tone_reg;
          2'b11: begin
            if (sum[SAMPLE_W] != sum[SAMPLE_W-1])
              out_next = sum[SAMPLE_W] ? SAT_MIN : SAT_MAX;
            else
              out_next = sum[SAMPLE_W-1:0];
          end
          default: out_next = '0;
        endcase
      end

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
          out_reg <= '0;
        else if (capture_valid_reg)
          out_reg <= out_next;
      end

      assign chan_out[gi] = out_reg;
    end
  endgenerate

  assign left_out  = chan_out[0];
  assign right_out = chan_out[1];

endmodule

// File: tb/tb_audio_proc_gen.sv
// Testbench for audio_proc_gen: directed frames from the usage scenarios plus
// randomized frames, checked against a frame-level reference model.
module tb_audio_proc_gen;

  localparam int AMP  = 32'h08000;
  localparam int LDIV = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ready;
  logic [19:0] left_in, right_in;
  logic [1:0]  mode;
  logic        mono;
  logic [2:0]  atten;
  logic [15:0] half_period;
  logic [19:0] left_out, right_out;
  logic        out_valid;
  logic        LED;

  int checks = 0;
  int passed = 0;

  // reference model state (frame level)
  int m_hp, m_cnt, m_ph, m_frames;

  audio_proc_gen #(.LED_DIV(LDIV)) dut (
    .clock(clock), .reset_n(reset_n), .ready(ready),
    .left_in(left_in), .right_in(right_in), .mode(mode), .mono(mono),
    .atten(atten), .half_period(half_period),
    .left_out(left_out), .right_out(right_out),
    .out_valid(out_valid), .LED(LED)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > 524287)  return 524287;
    if (v < -524288) return -524288;
    return v;
  endfunction

  // Expected outputs of one frame; advances the model's tone and frame state.
  task automatic model(input logic [1:0] md, input logic mn, input logic [2:0] at,
                       input logic [19:0] li, input logic [19:0] ri, input logic [15:0] hp,
                       output logic [19:0] el, output logic [19:0] er);
    int tone_v, il, ir, sl, sr, t;
    tone_v = (m_hp == 0) ? 0 : (m_ph != 0 ? AMP : -AMP);
    if (m_hp == 0) begin
      m_hp = int'(hp); m_ph = 0;
    end else if (m_cnt == m_hp - 1) begin
      m_cnt = 0; m_ph = 1 - m_ph; m_hp = int'(hp);
    end else begin
      m_cnt++;
    end
    t  = $signed(li);
    il = t >>> at;
    t  = $signed(mn ? li : ri);
    ir = t >>> at;
    case (md)
      2'b00:   begin sl = 0;      sr = 0;      end
      2'b01:   begin sl = il;     sr = ir;     end
      2'b10:   begin sl = tone_v; sr = tone_v; end
      default: begin sl = clamp(il + tone_v); sr = clamp(ir + tone_v); end
    endcase
    el = sl[19:0];
    er = sr[19:0];
    m_frames++;
  endtask

  // One frame: raise ready, scramble inputs once the strobe has passed,
  // measure latency and pulse count, compare the outputs.
  task automatic frame(input logic [1:0] md, input logic mn, input logic [2:0] at,
                       input logic [19:0] li, input logic [19:0] ri, input logic [15:0] hp,
                       input int hold, output logic [19:0] got_l, output logic [19:0] got_r);
    logic [19:0] el, er;
    int lat, pulses;
    model(md, mn, at, li, ri, hp, el, er);
    mode = md; mono = mn; atten = at; left_in = li; right_in = ri; half_period = hp;
    ready = 1'b1;
    lat = 0; pulses = 0; got_l = '0; got_r = '0;
    for (int i = 1; i <= 8 + hold; i++) begin
      @(negedge clock);
      if (i == 3) begin
        mode = 2'($urandom); mono = 1'($urandom); atten = 3'($urandom);
        left_in = 20'($urandom); right_in = 20'($urandom); half_period = 16'($urandom);
      end
      if (out_valid) begin
        pulses++;
        if (lat == 0) begin
          lat = i; got_l = left_out; got_r = right_out;
          check("left_out", 32'(left_out), 32'(el));
          check("right_out", 32'(right_out), 32'(er));
        end
      end
    end
    check("latency", 32'(lat), 32'd4);
    check("pulse_count", 32'(pulses), 32'd1);
    ready = 1'b0;
    repeat (3) @(negedge clock);
    check("led", 32'(LED), 32'((m_frames / (1 << LDIV)) % 2));
    $display("frame %0d mode=%0d mono=%0d atten=%0d in=%h/%h hp=%0d -> out=%h/%h lat=%0d",
             m_frames, md, mn, at, li, ri, hp, got_l, got_r, lat);
  endtask

  task automatic do_reset(input logic keep_ready);
    ready = keep_ready;
    reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_out", {12'd0, left_out | right_out}, 32'd0);
      check("rst_led", 32'(LED), 32'd0);
      ready = i[0];
    end
    ready = 1'b0;
    reset_n = 1'b1;
    m_hp = 0; m_cnt = 0; m_ph = 0; m_frames = 0;
    repeat (3) @(negedge clock);
    $display("reset done");
  endtask

  logic [19:0] gl, gr;
  logic [19:0] tone_exp;

  initial begin
    reset_n = 1'b0; ready = 1'b0; left_in = '0; right_in = '0;
    mode = 2'b00; mono = 1'b0; atten = 3'd0; half_period = '0;
    m_hp = 0; m_cnt = 0; m_ph = 0; m_frames = 0;

    do_reset(1'b0);

    // loopback and attenuation
    frame(2'b01, 1'b0, 3'd0, 20'h12345, 20'hFEDCB, 16'd0, 0, gl, gr);
    check("loop_l", 32'(gl), 32'h12345);
    check("loop_r", 32'(gr), 32'hFEDCB);
    frame(2'b01, 1'b0, 3'd2, 20'h80000, 20'h00010, 16'd0, 0, gl, gr);
    check("atten_l", 32'(gl), 32'hE0000);
    check("atten_r", 32'(gr), 32'h00004);

    // tone, half-period 4: frame 0 latches, then -AMP x4, +AMP x4, ...
    do_reset(1'b0);
    for (int f = 0; f <= 16; f++) begin
      frame(2'b10, 1'b0, 3'd0, 20'h11111, 20'h22222, 16'd4, 0, gl, gr);
      if (f >= 1) begin
        tone_exp = (((f - 1) / 4) % 2 == 0) ? 20'hF8000 : 20'h08000;
        check("tone", 32'(gl), 32'(tone_exp));
      end
    end

    // period change 4 -> 2 in the middle of the first half-period
    do_reset(1'b0);
    for (int f = 0; f <= 10; f++) begin
      frame(2'b10, 1'b0, 3'd0, 20'h0, 20'h0, (f < 3) ? 16'd4 : 16'd2, 0, gl, gr);
      if (f >= 1) begin
        if (f <= 4)      tone_exp = 20'hF8000;
        else             tone_exp = (((f - 5) / 2) % 2 == 0) ? 20'h08000 : 20'hF8000;
        check("period_change", 32'(gl), 32'(tone_exp));
      end
    end

    // mix saturation: hp=1, frame 1 is phase -, frame 2 is phase +
    do_reset(1'b0);
    frame(2'b11, 1'b0, 3'd0, 20'h00000, 20'h00000, 16'd1, 0, gl, gr);
    frame(2'b11, 1'b0, 3'd0, 20'h80100, 20'h00100, 16'd1, 0, gl, gr);
    check("sat_neg", 32'(gl), 32'h80000);
    frame(2'b11, 1'b0, 3'd0, 20'h7F000, 20'h00100, 16'd1, 0, gl, gr);
    check("sat_pos", 32'(gl), 32'h7FFFF);

    // mono with ready held high for 50 cycles: exactly one pulse
    frame(2'b01, 1'b1, 3'd0, 20'h3A5C7, 20'h11111, 16'd1, 42, gl, gr);
    check("mono_r", 32'(gr), 32'h3A5C7);

    // reset in the middle of a frame, with the strobe pending
    ready = 1'b1;
    repeat (2) @(negedge clock);
    do_reset(1'b1);

    // randomized frames, long enough for the heartbeat to toggle twice
    for (int n = 0; n < 40; n++) begin
      frame(2'($urandom), 1'($urandom), 3'($urandom), 20'($urandom), 20'($urandom),
            16'($urandom_range(0, 3)), 0, gl, gr);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
